// File: rtl/inst_fetch.sv
// Instruction fetch: PC drives a combinational ROM and each word is buffered with its PC in a
// DEPTH-entry FIFO. A word is visible one cycle after fetch; fetch stalls when the FIFO is full.
module inst_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {IDLE, FETCH} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  logic   push;
  logic   pop;
  entry_t head;

  always_comb begin
    pop  = (cnt_q != '0) & out_ready;
    push = (state_q == FETCH) & run & ~redirect_valid & ((cnt_q < DEPTH_C) | pop);

    state_d  = run ? FETCH : IDLE;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;

    // A redirect flushes everything; a pop in the same cycle is simply absorbed by the flush.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: pc_q, inst: imem_inst};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        pc_d            = pc_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign imem_addr = pc_q;
  assign out_valid = (cnt_q != '0);
  assign out_inst  = out_valid ? head.inst : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  assign busy      = (state_q == FETCH) | out_valid;

endmodule
